mos6502s_indirect_fetch: RTL and testbench

- Sequential pointer-fetch stage directly upstream of the address generator.
- For indirect addressing modes (9 = JMP (abs), A = (zp,X), B = (zp),Y), it reads the two pointer bytes from memory over a ready-qualified read port.
- It presents the fetched bytes as indirect_lo/indirect_hi, which feed the address generator's indirect inputs.
- Non-indirect modes complete without any memory access.

---
 rtl/mos6502s_indirect_fetch.sv | 247 ++++++++++++++++++++++++
 tb/tb_mos6502s_indirect_fetch.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mos6502s_indirect_fetch.sv
// ---------------------------------------------------------------------------
// mos6502s_indirect_fetch
//
// Pointer-fetch stage that sits directly upstream of the address generator.
// For the indirect addressing modes it reads the two pointer bytes from
// memory over a ready-qualified read port. It then presents them as
// indirect_lo / indirect_hi. Non-indirect modes complete without touching
// memory.
//
//   mode 9 : JMP (abs)   ptr = {operand_hi, operand_lo}
//   mode A : (zp,X)      ptr = {8'h00, operand_lo + x_reg}
//   mode B : (zp),Y      ptr = {8'h00, operand_lo}
//
// Parameters
//   NMOS_JMP_BUG  1: the JMP (abs) high-byte read wraps inside the page.
//                 0: the carry ripples into the page (CMOS behaviour).
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start        in   begin a fetch (sampled only while idle)
//   flush        in   synchronous abort back to idle
//   mode [3:0]   in   addressing mode (address generator encoding)
//   operand_lo   in   instruction operand low byte
//   operand_hi   in   instruction operand high byte
//   x_reg        in   X index register
//   mem_rd       out  read request
//   mem_addr     out  read address
//   mem_rdata    in   read data, valid with mem_ready
//   mem_ready    in   read completes on an edge with mem_rd & mem_ready
//   indirect_lo  out  fetched pointer low byte
//   indirect_hi  out  fetched pointer high byte
//   busy         out  high in every state except IDLE
//   done         out  one-cycle completion pulse
//
// All outputs are registered.
// ---------------------------------------------------------------------------
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_IDLE     | waiting for start
// ST_FETCH_LO | read of pointer low byte outstanding (mem_rd=1)
// ST_FETCH_HI | read of pointer high byte outstanding (mem_rd=1)
// ST_DONE     | done pulse cycle, returns to IDLE
// ---------------------------------------------------------------------------
module mos6502s_indirect_fetch #(
    parameter bit NMOS_JMP_BUG = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        flush,
    input  logic [3:0]  mode,
    input  logic [7:0]  operand_lo,
    input  logic [7:0]  operand_hi,
    input  logic [7:0]  x_reg,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready,
    output logic [7:0]  indirect_lo,
    output logic [7:0]  indirect_hi,
    output logic        busy,
    output logic        done
);

    localparam logic [3:0] MODE_JMP_IND  = 4'h9;
    localparam logic [3:0] MODE_ZPX_IND  = 4'hA;
    localparam logic [3:0] MODE_ZP_IND_Y = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FETCH_LO = 2'd1,
        ST_FETCH_HI = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    state_t      state_q, state_d;

    // Latched transaction context; only the pointer and the mode are
    // needed after the start cycle.
    logic [3:0]  mode_q, mode_d;
    logic [15:0] ptr_q, ptr_d;

    logic        mem_rd_d;
    logic [15:0] mem_addr_d;
    logic [7:0]  indirect_lo_d;
    logic [7:0]  indirect_hi_d;
    logic        busy_d;
    logic        done_d;

    logic        start_is_indirect;
    logic [7:0]  zpx_sum;
    logic [15:0] start_ptr;
    logic [7:0]  ptr_lo_inc;
    logic [15:0] ptr_hi_addr;

    // -----------------------------------------------------------------
    // Pointer arithmetic
    // -----------------------------------------------------------------
    assign start_is_indirect = (mode == MODE_JMP_IND) ||
                               (mode == MODE_ZPX_IND) ||
                               (mode == MODE_ZP_IND_Y);

    // 8-bit add: (zp,X) never leaves page zero.
    assign zpx_sum = operand_lo + x_reg;

    always_comb begin
        start_ptr = {8'h00, operand_lo};
        case (mode)
            MODE_JMP_IND:  start_ptr = {operand_hi, operand_lo};
            MODE_ZPX_IND:  start_ptr = {8'h00, zpx_sum};
            MODE_ZP_IND_Y: start_ptr = {8'h00, operand_lo};
            default:       start_ptr = {8'h00, operand_lo};
        endcase
    end

    assign ptr_lo_inc = ptr_q[7:0] + 8'd1;

    // Address of the pointer high byte. Zero-page pointers always wrap
    // inside page zero. JMP (abs) either reproduces the NMOS page-wrap
    // bug or carries into the page byte.
    always_comb begin
        ptr_hi_addr = {8'h00, ptr_lo_inc};
        if (mode_q == MODE_JMP_IND) begin
            if (NMOS_JMP_BUG) begin
                ptr_hi_addr = {ptr_q[15:8], ptr_lo_inc};
            end else begin
                ptr_hi_addr = ptr_q + 16'd1;
            end
        end
    end

    // -----------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= 4'h0;
            ptr_q       <= 16'h0000;
            mem_rd      <= 1'b0;
            mem_addr    <= 16'h0000;
            indirect_lo <= 8'h00;
            indirect_hi <= 8'h00;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            ptr_q       <= ptr_d;
            mem_rd      <= mem_rd_d;
            mem_addr    <= mem_addr_d;
            indirect_lo <= indirect_lo_d;
            indirect_hi <= indirect_hi_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

    // -----------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = start_is_indirect ? ST_FETCH_LO : ST_DONE;
                    end
                end
                ST_FETCH_LO: begin
                    if (mem_ready) begin
                        state_d = ST_FETCH_HI;
                    end
                end
                ST_FETCH_HI: begin
                    if (mem_ready) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------
    // Output / datapath next values
    // -----------------------------------------------------------------
    always_comb begin
        mode_d        = mode_q;
        ptr_d         = ptr_q;
        mem_rd_d      = mem_rd;
        mem_addr_d    = mem_addr;
        indirect_lo_d = indirect_lo;
        indirect_hi_d = indirect_hi;

        if (flush) begin
            // A read completing on the flush edge is dropped; mem_addr
            // simply keeps its last value.
            mem_rd_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mode_d = mode;
                        ptr_d  = start_ptr;
                        if (start_is_indirect) begin
                            mem_rd_d   = 1'b1;
                            mem_addr_d = start_ptr;
                        end
                    end
                end
                ST_FETCH_LO: begin
                    if (mem_ready) begin
                        indirect_lo_d = mem_rdata;
                        mem_addr_d    = ptr_hi_addr;
                    end
                end
                ST_FETCH_HI: begin
                    if (mem_ready) begin
                        indirect_hi_d = mem_rdata;
                        mem_rd_d      = 1'b0;
                    end
                end
                ST_DONE: begin
                end
                default: begin
                    mem_rd_d = 1'b0;
                end
            endcase
        end

        // busy/done are registered copies of the state being entered so
        // they line up exactly with the state register.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

endmodule

// File: tb/tb_mos6502s_indirect_fetch.sv
module tb_mos6502s_indirect_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [3:0]  mode;
    logic [7:0]  operand_lo;
    logic [7:0]  operand_hi;
    logic [7:0]  x_reg;
    logic        mem_ready = 1'b1;

    // Instance 0: NMOS JMP bug, instance 1: CMOS carry. Same stimulus.
    logic        mem_rd0, mem_rd1;
    logic [15:0] mem_addr0, mem_addr1;
    logic [7:0]  rdata0, rdata1;
    logic [7:0]  lo0, hi0, lo1, hi1;
    logic        busy0, busy1, done0, done1;

    logic [7:0]  mem [0:65535];

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] exp_addr0[$];
    logic [15:0] exp_addr1[$];
    logic [15:0] exp_res0[$];
    logic [15:0] exp_res1[$];

    int wait_cfg = 0;
    int wcnt     = 0;

    always #5 clk = ~clk;

    assign rdata0 = mem[mem_addr0];
    assign rdata1 = mem[mem_addr1];

    mos6502s_indirect_fetch #(.NMOS_JMP_BUG(1'b1)) u_dut_nmos (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .mode(mode),
        .operand_lo(operand_lo), .operand_hi(operand_hi), .x_reg(x_reg),
        .mem_rd(mem_rd0), .mem_addr(mem_addr0), .mem_rdata(rdata0),
        .mem_ready(mem_ready), .indirect_lo(lo0), .indirect_hi(hi0),
        .busy(busy0), .done(done0)
    );

    mos6502s_indirect_fetch #(.NMOS_JMP_BUG(1'b0)) u_dut_cmos (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .mode(mode),
        .operand_lo(operand_lo), .operand_hi(operand_hi), .x_reg(x_reg),
        .mem_rd(mem_rd1), .mem_addr(mem_addr1), .mem_rdata(rdata1),
        .mem_ready(mem_ready), .indirect_lo(lo1), .indirect_hi(hi1),
        .busy(busy1), .done(done1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: unexpected event at %0t", name, $time);
    endtask

    // Memory ready generator: wait_cfg wait cycles in front of every read.
    always @(posedge clk) begin
        #1;
        if (mem_rd0) begin
            if (wcnt < wait_cfg) begin
                mem_ready = 1'b0;
                wcnt++;
            end else begin
                mem_ready = 1'b1;
                wcnt = 0;
            end
        end else begin
            mem_ready = 1'b1;
            wcnt = 0;
        end
    end

    // Monitors: sampled on the falling edge, between stimulus updates.
    always @(negedge clk) begin
        logic [15:0] e;
        if (rst_n) begin
            if (mem_rd0) begin
                if (exp_addr0.size() == 0) flag("nmos_rd_unexpected");
                else begin
                    check("nmos_rd_addr", {16'h0, mem_addr0}, {16'h0, exp_addr0[0]});
                    if (mem_ready) void'(exp_addr0.pop_front());
                end
            end
            if (done0) begin
                if (exp_res0.size() == 0) flag("nmos_done_unexpected");
                else begin
                    e = exp_res0.pop_front();
                    check("nmos_result", {16'h0, hi0, lo0}, {16'h0, e});
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [15:0] e;
        if (rst_n) begin
            if (mem_rd1) begin
                if (exp_addr1.size() == 0) flag("cmos_rd_unexpected");
                else begin
                    check("cmos_rd_addr", {16'h0, mem_addr1}, {16'h0, exp_addr1[0]});
                    if (mem_ready) void'(exp_addr1.pop_front());
                end
            end
            if (done1) begin
                if (exp_res1.size() == 0) flag("cmos_done_unexpected");
                else begin
                    e = exp_res1.pop_front();
                    check("cmos_result", {16'h0, hi1, lo1}, {16'h0, e});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one start and count edges until done; edge 0 samples start.
    task automatic run_txn(input string name, input logic [3:0] m, input logic [7:0] lo,
                           input logic [7:0] hi, input logic [7:0] x, input int exp_cycles);
        int  n = 0;
        bit  got = 0;
        bit  busy_ok = 1;
        start = 1'b1; mode = m; operand_lo = lo; operand_hi = hi; x_reg = x;
        for (int i = 0; i < 50 && !got; i++) begin
            step();
            start = 1'b0;
            n++;
            if (done0) got = 1;
            else if (!busy0) busy_ok = 0;
        end
        check({name, "_latency"}, n, exp_cycles);
        check({name, "_busy"}, {30'h0, busy_ok, busy0}, 32'h3);
        step();
        check({name, "_end"}, {30'h0, done0, busy0}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; mode = 4'h0;
        operand_lo = 8'h00; operand_hi = 8'h00; x_reg = 8'h00;
        #12;
        check("rst_addr", {16'h0, mem_addr0}, 32'h0);
        check("rst_ind", {16'h0, hi0, lo0}, 32'h0);
        check("rst_ctl", {29'h0, mem_rd0, busy0, done0}, 32'h0);
        rst_n = 1'b1;
        step();

        // (zp,X) with zero-page wrap: $FE + $01 = $FF, high byte at $00
        mem[16'h00FF] = 8'h34; mem[16'h0000] = 8'h12;
        exp_addr0.push_back(16'h00FF); exp_addr0.push_back(16'h0000);
        exp_addr1.push_back(16'h00FF); exp_addr1.push_back(16'h0000);
        exp_res0.push_back(16'h1234);  exp_res1.push_back(16'h1234);
        run_txn("zpx_wrap", 4'hA, 8'hFE, 8'h00, 8'h01, 3);

        // JMP ($02FF): NMOS reads high byte at $0200, CMOS at $0300
        mem[16'h02FF] = 8'h00; mem[16'h0200] = 8'h80; mem[16'h0300] = 8'h90;
        exp_addr0.push_back(16'h02FF); exp_addr0.push_back(16'h0200);
        exp_addr1.push_back(16'h02FF); exp_addr1.push_back(16'h0300);
        exp_res0.push_back(16'h8000);  exp_res1.push_back(16'h9000);
        run_txn("jmp_bug", 4'h9, 8'hFF, 8'h02, 8'h00, 3);

        // (zp),Y with two wait states per read
        wait_cfg = 2;
        mem[16'h0040] = 8'h78; mem[16'h0041] = 8'h56;
        exp_addr0.push_back(16'h0040); exp_addr0.push_back(16'h0041);
        exp_addr1.push_back(16'h0040); exp_addr1.push_back(16'h0041);
        exp_res0.push_back(16'h5678);  exp_res1.push_back(16'h5678);
        run_txn("wait_b", 4'hB, 8'h40, 8'h00, 8'h00, 7);
        wait_cfg = 0;

        // Absolute: no memory access, pointer bytes unchanged
        exp_res0.push_back(16'h5678);  exp_res1.push_back(16'h5678);
        run_txn("non_ind", 4'h6, 8'h12, 8'h34, 8'h00, 1);

        // Start while busy ignored; flush in FETCH_HI with ready drops the byte
        mem[16'h0010] = 8'hAB; mem[16'h0011] = 8'hCD;
        exp_addr0.push_back(16'h0010); exp_addr0.push_back(16'h0011);
        exp_addr1.push_back(16'h0010); exp_addr1.push_back(16'h0011);
        start = 1'b1; mode = 4'hA; operand_lo = 8'h10; operand_hi = 8'h00; x_reg = 8'h00;
        step();
        mode = 4'h6; operand_lo = 8'h77;
        check("flush_in_lo", {30'h0, mem_rd0, busy0}, 32'h3);
        step();
        start = 1'b0; flush = 1'b1;
        check("flush_hi_addr", {16'h0, mem_addr0}, 32'h0011);
        check("flush_lo_byte", {24'h0, lo0}, 32'h00AB);
        step();
        flush = 1'b0;
        check("flush_idle", {29'h0, mem_rd0, busy0, done0}, 32'h0);
        check("flush_nmos_ind", {16'h0, hi0, lo0}, 32'h56AB);
        check("flush_cmos_ind", {16'h0, hi1, lo1}, 32'h56AB);
        step();
        check("flush_no_done", {31'h0, done0}, 32'h0);
        step();

        // Asynchronous reset in the middle of a waited FETCH_LO
        wait_cfg = 5;
        exp_addr0.push_back(16'h0020); exp_addr1.push_back(16'h0020);
        start = 1'b1; mode = 4'hB; operand_lo = 8'h20;
        step();
        start = 1'b0;
        step();
        check("arst_pre", {30'h0, mem_rd0, busy0}, 32'h3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_addr", {16'h0, mem_addr0}, 32'h0);
        check("arst_ind", {16'h0, hi0, lo0}, 32'h0);
        check("arst_ctl", {29'h0, mem_rd0, busy0, done0}, 32'h0);
        exp_addr0.delete(); exp_addr1.delete();
        wait_cfg = 0;
        #3;
        rst_n = 1'b1;
        step();
        step();
        check("arst_idle", {30'h0, busy0, done0}, 32'h0);

        check("queues_empty", exp_addr0.size() + exp_addr1.size() +
                              exp_res0.size() + exp_res1.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
